// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Optional build macro MDU_FLUSH_EN adds a Flush port that aborts an in-flight op.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             MtHi,
    input  logic             MtLo,
`ifdef MDU_FLUSH_EN
    input  logic             Flush,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] FIXUP = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               isDiv_q, isDiv_d;
    logic               negRes_q, negRes_d;
    logic               negRem_q, negRem_d;
    logic               divZero_q, divZero_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               flushReq;
    logic               signedOp;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH-1:0]   mulAddend;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift, divDiff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, remOut;

`ifdef MDU_FLUSH_EN
    assign flushReq = Flush;
`else
    assign flushReq = 1'b0;
`endif

    assign signedOp  = Op[0];
    assign absA      = (signedOp && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    assign absB      = (signedOp && SrcB[WIDTH-1]) ? -SrcB : SrcB;

    assign mulAddend = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
    assign mulSum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mulAddend};

    // Partial remainder is one bit wider so the trial subtraction's borrow is visible.
    assign divShift  = {rem_q, acc_q[WIDTH-1]};
    assign divDiff   = divShift - {1'b0, opnd_q};

    assign prod      = negRes_q ? -acc_q : acc_q;
    assign quot      = divZero_q ? {WIDTH{1'b1}}
                     : (negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign remOut    = negRem_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opnd_d    = opnd_q;
        isDiv_d   = isDiv_q;
        negRes_d  = negRes_q;
        negRem_d  = negRem_q;
        divZero_d = divZero_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (Start && !flushReq) begin
                    state_d   = CALC;
                    count_d   = '0;
                    isDiv_d   = Op[1];
                    negRes_d  = signedOp && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                    negRem_d  = signedOp && SrcA[WIDTH-1];
                    divZero_d = Op[1] && (SrcB == '0);
                    rem_d     = '0;
                    acc_d     = Op[1] ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
                    opnd_d    = Op[1] ? absB : absA;
                end else if (!Start) begin
                    if (MtHi) hi_d = SrcA;
                    if (MtLo) lo_d = SrcA;
                end
            end
            CALC: begin
                if (flushReq) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    if (isDiv_q) begin
                        if (!divDiff[WIDTH]) begin
                            rem_d = divDiff[WIDTH-1:0];
                            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_d = divShift[WIDTH-1:0];
                            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mulSum, acc_q[WIDTH-1:1]};
                    end
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_d = FIXUP;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            FIXUP: begin
                state_d = IDLE;
                count_d = '0;
                if (!flushReq) begin
                    done_d = 1'b1;
                    if (isDiv_q) begin
                        hi_d = remOut;
                        lo_d = quot;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opnd_q    <= '0;
            isDiv_q   <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opnd_q    <= opnd_d;
            isDiv_q   <= isDiv_d;
            negRes_q  <= negRes_d;
            negRem_q  <= negRem_d;
            divZero_q <= divZero_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign Busy = (state_q != IDLE);
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic reference model.
// Build with MDU_FLUSH_EN defined to also exercise the Flush port.
module tb_mult_div_unit;

    localparam int W = 32;
    localparam logic [1:0] OP_MULTU = 2'd0;
    localparam logic [1:0] OP_MULT  = 2'd1;
    localparam logic [1:0] OP_DIVU  = 2'd2;
    localparam logic [1:0] OP_DIV   = 2'd3;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] SrcA, SrcB;
    logic         MtHi, MtLo;
    logic         Busy, Done;
    logic [W-1:0] Hi, Lo;
`ifdef MDU_FLUSH_EN
    logic         Flush;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] hiModel, loModel;

    mult_div_unit #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .Start (Start),
        .Op    (Op),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .MtHi  (MtHi),
        .MtLo  (MtLo),
`ifdef MDU_FLUSH_EN
        .Flush (Flush),
`endif
        .Busy  (Busy),
        .Done  (Done),
        .Hi    (Hi),
        .Lo    (Lo)
    );

    always #5 CLK = ~CLK;

    // Architectural result {HI, LO} computed with plain 64-bit arithmetic.
    function automatic logic [2*W-1:0] refModel(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        case (op)
            OP_MULTU: begin
                p = 64'(a) * 64'(b);
                return p;
            end
            OP_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                return p;
            end
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Called at a negedge; returns 1ns after the launching edge.
    task automatic launchOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic mtHi, input logic mtLo);
        Start = 1'b1; Op = op; SrcA = a; SrcB = b; MtHi = mtHi; MtLo = mtLo;
        @(posedge CLK); #1;
        Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
        SrcA = $urandom; SrcB = $urandom; Op = 2'($urandom);
    endtask

    // Index i is the cycle after edge k+i+1's predecessor: i=0 follows the Start edge.
    task automatic waitResult(input int pokeAt,
                              output logic [W-1:0] hiOut, output logic [W-1:0] loOut,
                              output int doneIdx, output int busyCnt,
                              output logic [W-1:0] hiPoke, output logic [W-1:0] loPoke);
        doneIdx = -1; busyCnt = 0; hiOut = '0; loOut = '0; hiPoke = '0; loPoke = '0;
        for (int i = 0; i < W + 20; i++) begin
            @(negedge CLK);
            if (i == pokeAt + 1) begin hiPoke = Hi; loPoke = Lo; end
            Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
            if (Done === 1'b1) begin
                doneIdx = i; hiOut = Hi; loOut = Lo;
                break;
            end
            if (Busy === 1'b1) busyCnt++;
            if (i == pokeAt) begin
                Start = 1'b1; MtHi = 1'b1; MtLo = 1'b1;
                SrcA = $urandom; SrcB = $urandom; Op = 2'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; Start = 1'b1; Op = OP_MULT; MtHi = 1'b1; MtLo = 1'b1;
        SrcA = $urandom; SrcB = $urandom;
`ifdef MDU_FLUSH_EN
        Flush = 1'b0;
`endif
        @(posedge CLK); #1;
        RST_N = 1'b1; Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
        @(negedge CLK);
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", Done); end
        checks++; if (Hi !== '0) begin errors++; $display("[TB] FAIL reset_hi got %h expected 0", Hi); end
        checks++; if (Lo !== '0) begin errors++; $display("[TB] FAIL reset_lo got %h expected 0", Lo); end
        hiModel = '0; loModel = '0;
    endtask

    task automatic test_mult();
        logic [1:0] op; logic [W-1:0] a, b, h, l, hp, lp; logic [2*W-1:0] exp;
        int dIdx, bCnt;
        for (int n = 0; n < 10; n++) begin
            case (n)
                0: begin op = OP_MULT;  a = 32'hFFFF_FFFE; b = 32'd3; end
                1: begin op = OP_MULTU; a = 32'hFFFF_FFFE; b = 32'd3; end
                2: begin op = OP_MULT;  a = 32'h8000_0000; b = 32'h8000_0000; end
                3: begin op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
                default: begin op = 2'($urandom_range(0, 1)); a = $urandom; b = $urandom; end
            endcase
            exp = refModel(op, a, b);
            launchOp(op, a, b, 1'b0, 1'b0);
            waitResult(-1, h, l, dIdx, bCnt, hp, lp);
            checks++; if ({h, l} !== exp) begin errors++; $display("[TB] FAIL mult[%0d] op=%0d a=%h b=%h got %h_%h expected %h_%h", n, op, a, b, h, l, exp[63:32], exp[31:0]); end
            checks++; if (dIdx != W + 1) begin errors++; $display("[TB] FAIL mult_latency[%0d] got %0d expected %0d", n, dIdx, W + 1); end
            checks++; if (bCnt != W + 1) begin errors++; $display("[TB] FAIL mult_busy[%0d] got %0d expected %0d", n, bCnt, W + 1); end
            @(negedge CLK);
            checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL mult_done_pulse[%0d] got %b expected 0", n, Done); end
            hiModel = exp[63:32]; loModel = exp[31:0];
        end
    endtask

    task automatic test_div();
        logic [1:0] op; logic [W-1:0] a, b, h, l, hp, lp; logic [2*W-1:0] exp;
        int dIdx, bCnt;
        for (int n = 0; n < 12; n++) begin
            case (n)
                0: begin op = OP_DIV;  a = 32'hFFFF_FFF9; b = 32'd2; end
                1: begin op = OP_DIVU; a = 32'd7;         b = 32'd0; end
                2: begin op = OP_DIV;  a = 32'hFFFF_FFF9; b = 32'd0; end
                3: begin op = OP_DIV;  a = 32'd7;         b = 32'hFFFF_FFFE; end
                4: begin op = OP_DIVU; a = 32'hFFFF_FFFF; b = 32'h8000_0000; end
                5: begin op = OP_DIV;  a = 32'h8000_0000; b = 32'd7; end
                default: begin
                    op = 2'($urandom_range(2, 3)); a = $urandom;
                    b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
                end
            endcase
            exp = refModel(op, a, b);
            launchOp(op, a, b, 1'b0, 1'b0);
            waitResult(-1, h, l, dIdx, bCnt, hp, lp);
            checks++; if ({h, l} !== exp) begin errors++; $display("[TB] FAIL div[%0d] op=%0d a=%h b=%h got %h_%h expected %h_%h", n, op, a, b, h, l, exp[63:32], exp[31:0]); end
            checks++; if (dIdx != W + 1) begin errors++; $display("[TB] FAIL div_latency[%0d] got %0d expected %0d", n, dIdx, W + 1); end
            hiModel = exp[63:32]; loModel = exp[31:0];
        end
    endtask

    task automatic test_overflow_busy();
        logic [W-1:0] h, l, hp, lp, hPrev, lPrev; int dIdx, bCnt;
        hPrev = hiModel; lPrev = loModel;
        launchOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        waitResult(5, h, l, dIdx, bCnt, hp, lp);
        checks++; if (hp !== hPrev || lp !== lPrev) begin errors++; $display("[TB] FAIL busy_mt_ignored got %h_%h expected %h_%h", hp, lp, hPrev, lPrev); end
        checks++; if (h !== 32'h0 || l !== 32'h8000_0000) begin errors++; $display("[TB] FAIL div_overflow got %h_%h expected 00000000_80000000", h, l); end
        checks++; if (bCnt != W + 1) begin errors++; $display("[TB] FAIL overflow_busy got %0d expected %0d", bCnt, W + 1); end
        checks++; if (dIdx != W + 1) begin errors++; $display("[TB] FAIL overflow_latency got %0d expected %0d", dIdx, W + 1); end
        @(negedge CLK);
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL restart_not_queued got %b expected 0", Busy); end
        hiModel = 32'h0; loModel = 32'h8000_0000;
    endtask

    task automatic test_move();
        logic [W-1:0] v, a, b, h, l, hp, lp; logic [2*W-1:0] exp; int dIdx, bCnt;
        MtHi = 1'b1; SrcA = 32'h1234;
        @(posedge CLK); #1; MtHi = 1'b0;
        @(negedge CLK);
        checks++; if (Hi !== 32'h1234 || Lo !== loModel) begin errors++; $display("[TB] FAIL mthi got %h_%h expected %h_%h", Hi, Lo, 32'h1234, loModel); end
        hiModel = 32'h1234;
        v = $urandom; MtHi = 1'b1; MtLo = 1'b1; SrcA = v;
        @(posedge CLK); #1; MtHi = 1'b0; MtLo = 1'b0;
        @(negedge CLK);
        checks++; if (Hi !== v || Lo !== v) begin errors++; $display("[TB] FAIL mthi_mtlo got %h_%h expected %h_%h", Hi, Lo, v, v); end
        hiModel = v; loModel = v;
        a = $urandom; b = $urandom; exp = refModel(OP_MULTU, a, b);
        launchOp(OP_MULTU, a, b, 1'b1, 1'b1);
        waitResult(-1, h, l, dIdx, bCnt, hp, lp);
        checks++; if (hp !== v || lp !== v) begin errors++; $display("[TB] FAIL start_beats_mt got %h_%h expected %h_%h", hp, lp, v, v); end
        checks++; if ({h, l} !== exp) begin errors++; $display("[TB] FAIL start_with_mt_result got %h_%h expected %h_%h", h, l, exp[63:32], exp[31:0]); end
        hiModel = exp[63:32]; loModel = exp[31:0];
    endtask

    task automatic test_back_to_back();
        logic [1:0] op1, op2; logic [W-1:0] a1, b1, a2, b2, h, l, hp, lp;
        logic [2*W-1:0] e1, e2; int dIdx, bCnt;
        op1 = 2'($urandom); a1 = $urandom; b1 = $urandom;
        op2 = 2'($urandom); a2 = $urandom; b2 = $urandom;
        e1 = refModel(op1, a1, b1); e2 = refModel(op2, a2, b2);
        launchOp(op1, a1, b1, 1'b0, 1'b0);
        waitResult(-1, h, l, dIdx, bCnt, hp, lp);
        checks++; if ({h, l} !== e1) begin errors++; $display("[TB] FAIL b2b_first got %h_%h expected %h_%h", h, l, e1[63:32], e1[31:0]); end
        launchOp(op2, a2, b2, 1'b0, 1'b0);
        waitResult(-1, h, l, dIdx, bCnt, hp, lp);
        checks++; if ({h, l} !== e2) begin errors++; $display("[TB] FAIL b2b_second got %h_%h expected %h_%h", h, l, e2[63:32], e2[31:0]); end
        checks++; if (dIdx != W + 1) begin errors++; $display("[TB] FAIL b2b_latency got %0d expected %0d", dIdx, W + 1); end
        hiModel = e2[63:32]; loModel = e2[31:0];
    endtask

    task automatic test_reset_midop();
        int doneSeen = 0;
        launchOp(OP_MULTU, $urandom, $urandom, 1'b0, 1'b0);
        repeat (8) @(negedge CLK);
        RST_N = 1'b0;
        @(posedge CLK); #1; RST_N = 1'b1;
        @(negedge CLK);
        checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("[TB] FAIL midop_reset_ctrl got busy=%b done=%b expected 0 0", Busy, Done); end
        checks++; if (Hi !== '0 || Lo !== '0) begin errors++; $display("[TB] FAIL midop_reset_hilo got %h_%h expected 0_0", Hi, Lo); end
        repeat (W + 4) begin @(negedge CLK); if (Done !== 1'b0) doneSeen++; end
        checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL midop_reset_no_done got %0d expected 0", doneSeen); end
        hiModel = '0; loModel = '0;
    endtask

`ifdef MDU_FLUSH_EN
    task automatic test_flush();
        logic [W-1:0] v; int doneSeen = 0; int busySeen = 0;
        v = $urandom; MtHi = 1'b1; MtLo = 1'b1; SrcA = v;
        @(posedge CLK); #1; MtHi = 1'b0; MtLo = 1'b0;
        @(negedge CLK);
        launchOp(OP_MULTU, 32'd5, 32'd5, 1'b0, 1'b0);
        repeat (9) @(negedge CLK);
        Flush = 1'b1;
        @(posedge CLK); #1; Flush = 1'b0;
        @(negedge CLK);
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy got %b expected 0", Busy); end
        checks++; if (Hi !== v || Lo !== v) begin errors++; $display("[TB] FAIL flush_hilo got %h_%h expected %h_%h", Hi, Lo, v, v); end
        Start = 1'b1; Flush = 1'b1; Op = OP_MULTU; SrcA = $urandom; SrcB = $urandom;
        @(posedge CLK); #1; Start = 1'b0; Flush = 1'b0;
        repeat (W + 4) begin
            @(negedge CLK);
            if (Done !== 1'b0) doneSeen++;
            if (Busy !== 1'b0) busySeen++;
        end
        checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL flush_no_done got %0d expected 0", doneSeen); end
        checks++; if (busySeen != 0) begin errors++; $display("[TB] FAIL flush_beats_start got %0d expected 0", busySeen); end
        checks++; if (Hi !== v || Lo !== v) begin errors++; $display("[TB] FAIL flush_hilo_final got %h_%h expected %h_%h", Hi, Lo, v, v); end
        hiModel = v; loModel = v;
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_overflow_busy();
        test_move();
        test_back_to_back();
        test_reset_midop();
`ifdef MDU_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
